// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between the
// instruction-fetch and data ports, with one transaction outstanding at a time.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int          BE_W    = DATA_W / 8;
    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_WAIT = 1'b1;
    localparam logic [2:0]  LAT_END = 3'(MEM_LAT);

    logic [0:0] state;
    logic [2:0] lat_cnt;
    logic       last_winner;
    logic       owner;
    logic       we_latched;

    logic              grant_s;
    logic              winner_s;
    logic              done_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [1:0]        unused_addr_bits_s;

    assign unused_addr_bits_s = if_addr[1:0] ^ dm_addr[1:0];

    // Pick a winner in IDLE; on a conflict the side that lost last time goes first.
    always_comb begin
        grant_s  = 1'b0;
        winner_s = 1'b0;
        if (!rst && state == ST_IDLE && (if_req || dm_req)) begin
            grant_s = 1'b1;
            if (if_req && dm_req) begin
                winner_s = ~last_winner;
            end else begin
                winner_s = dm_req;
            end
        end else begin
            grant_s  = 1'b0;
            winner_s = 1'b0;
        end
        done_s = !rst && (state == ST_WAIT) && (lat_cnt == LAT_END);
    end

    // Request-side memory strobes and grants, routed from the winner.
    always_comb begin
        if_gnt     = grant_s & ~winner_s;
        dm_gnt     = grant_s & winner_s;
        mem_en     = grant_s;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_be     = '0;
        sel_addr_s = winner_s ? dm_addr : if_addr;
        if (grant_s) begin
            mem_addr = {sel_addr_s[ADDR_W-1:2], 2'b00};
            mem_be   = {BE_W{1'b1}};
            if (winner_s) begin
                mem_we    = dm_we;
                mem_wdata = dm_wdata;
                mem_be    = dm_we ? dm_be : {BE_W{1'b1}};
            end else begin
                mem_we    = 1'b0;
                mem_wdata = '0;
            end
        end else begin
            mem_we = 1'b0;
        end
    end

    // Response routing back to the owner; write acks carry zero data.
    always_comb begin
        if_rvalid = done_s & ~owner;
        dm_rvalid = done_s & owner;
        if_rdata  = '0;
        dm_rdata  = '0;
        if (if_rvalid) begin
            if_rdata = mem_rdata;
        end else if (dm_rvalid && !we_latched) begin
            dm_rdata = mem_rdata;
        end else begin
            if_rdata = '0;
            dm_rdata = '0;
        end
        busy = (state == ST_WAIT);
    end

    // Transaction state: one outstanding access, latency counted from issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            lat_cnt     <= 3'd0;
            last_winner <= 1'b0;
            owner       <= 1'b0;
            we_latched  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_s) begin
                        state       <= ST_WAIT;
                        lat_cnt     <= 3'd1;
                        last_winner <= winner_s;
                        owner       <= winner_s;
                        we_latched  <= mem_we;
                    end
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt + 3'd1;
                    if (done_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: two arbiter instances (MEM_LAT 1 and 3) checked every cycle
// against a transaction-level timing model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   mode = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    task automatic chk(input int lat, input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL lat=%0d %s: got %h expected %h", lat, tag, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_lat
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
        logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0, mem_rdata = '0;
        logic [3:0]  dm_be = '0;
        logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
        logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
        logic [3:0]  mem_be;

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
            .clk(clk), .rst(rst),
            .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
            .if_rvalid(if_rvalid), .if_rdata(if_rdata),
            .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
            .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
            .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
            .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
        );

        // model state: absolute cycle number at which the pending response is due
        int  cyc = 0;
        bit  m_busy = 0, m_owner = 0, m_we = 0, m_last = 0;
        int  resp_cyc = 0;
        bit  just_granted = 0;
        bit  e_ig, e_dg, e_iv, e_dv, e_en, e_we, e_busy, win;
        logic [31:0] e_ird, e_drd, e_addr, e_wd;
        logic [3:0]  e_be;

        always @(negedge clk) begin
            cyc++;
            e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_en = 0; e_we = 0; e_busy = 0;
            e_ird = '0; e_drd = '0; e_addr = '0; e_wd = '0; e_be = '0;
            if (rst) begin
                m_busy = 0;
                m_last = 0;
            end else begin
                e_busy = m_busy;
                if (m_busy && cyc == resp_cyc) begin
                    if (m_owner) begin
                        e_dv = 1;
                        e_drd = m_we ? 32'h0 : mem_rdata;
                    end else begin
                        e_iv = 1;
                        e_ird = mem_rdata;
                    end
                    m_busy = 0;
                end else if (!m_busy && (if_req || dm_req)) begin
                    win = (if_req && dm_req) ? !m_last : dm_req;
                    e_en = 1;
                    if (win) begin
                        e_dg = 1;
                        e_we = dm_we;
                        e_addr = dm_addr & 32'hFFFF_FFFC;
                        e_wd = dm_wdata;
                        e_be = dm_we ? dm_be : 4'hF;
                    end else begin
                        e_ig = 1;
                        e_addr = if_addr & 32'hFFFF_FFFC;
                        e_be = 4'hF;
                    end
                    m_busy = 1; resp_cyc = cyc + LAT;
                    m_last = win; m_owner = win; m_we = win ? dm_we : 1'b0;
                end
            end
            just_granted = e_ig | e_dg;
            chk(LAT, "if_gnt",    64'(if_gnt),    64'(e_ig));
            chk(LAT, "dm_gnt",    64'(dm_gnt),    64'(e_dg));
            chk(LAT, "if_rvalid", 64'(if_rvalid), 64'(e_iv));
            chk(LAT, "dm_rvalid", 64'(dm_rvalid), 64'(e_dv));
            chk(LAT, "if_rdata",  64'(if_rdata),  64'(e_ird));
            chk(LAT, "dm_rdata",  64'(dm_rdata),  64'(e_drd));
            chk(LAT, "mem_en",    64'(mem_en),    64'(e_en));
            chk(LAT, "mem_we",    64'(mem_we),    64'(e_we));
            chk(LAT, "mem_addr",  64'(mem_addr),  64'(e_addr));
            chk(LAT, "mem_wdata", 64'(mem_wdata), 64'(e_wd));
            chk(LAT, "mem_be",    64'(mem_be),    64'(e_be));
            chk(LAT, "busy",      64'(busy),      64'(e_busy));
        end

        // requesters: hold each request until granted, then issue the next per mode
        initial forever begin
            @(posedge clk);
            #1;
            if (e_ig) if_req = 0;
            if (e_dg) dm_req = 0;
            if (!if_req) begin
                case (mode)
                    1: begin if_req = 1; if_addr = 32'h8000_0004; end
                    3: if ($urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom; end
                    4: begin if_req = 1; if_addr = $urandom; end
                    default: ;
                endcase
            end
            if (!dm_req) begin
                case (mode)
                    1: begin dm_req = 1; dm_we = 0; dm_addr = 32'h8000_1000; dm_wdata = $urandom; dm_be = 4'($urandom); end
                    2: begin dm_req = 1; dm_we = 1; dm_addr = 32'h8000_1002; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011; end
                    3: if ($urandom_range(0, 2) == 0) begin
                           dm_req = 1; dm_we = 1'($urandom); dm_addr = $urandom;
                           dm_wdata = $urandom; dm_be = 4'($urandom);
                       end
                    5: begin dm_req = 1; dm_we = 0; dm_addr = $urandom; dm_wdata = $urandom; dm_be = 4'($urandom); end
                    default: ;
                endcase
            end
            mem_rdata = $urandom;
        end
    end

    task automatic run(input int m, input int cycles);
        mode = m;
        repeat (cycles) @(posedge clk);
    endtask

    initial begin
        bit found;
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        run(1, 12);
        run(0, 8);
        run(2, 10);
        run(0, 8);
        run(5, 15);
        run(0, 8);
        run(4, 20);
        // reset the MEM_LAT=3 instance one cycle into its wait phase
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            found = gen_lat[1].just_granted;
        end
        if (!found) chk(3, "rst_wait_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1 rst = 1;
        mode = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        run(1, 12);
        run(3, 400);
        run(0, 10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
